// File: rtl/expr_buffer.sv
// Expression character buffer: loads one ASCII character per handshake,
// then presents the character at the read pointer, pre-classified, to the
// calculator controller.
module expr_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          clear,
  input  logic          rewind,
  input  logic          index_cnt,
  output logic          loaded,
  output logic [7:0]    cur_char,
  output logic [3:0]    digit,
  output logic          is_operand,
  output logic          is_operator,
  output logic          is_hash,
  output logic          err,
  output logic          overflow,
  output logic [AW:0]   wr_count
);

  typedef enum logic {LOAD, LOADED} state_t;

  localparam logic [AW:0] LAST_FREE = (AW+1)'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   wr_cnt_q;
  logic          err_q, ovf_q;

  logic in_digit, in_op, in_hash, in_space;
  logic xfer, full, do_write, go_loaded, bad_char, at_end;
  logic [7:0] wr_char;

  // Classify the incoming character and decide what a transfer does.
  always_comb begin
    in_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
    in_op     = (in_data == 8'h2B) || (in_data == 8'h2D) ||
                (in_data == 8'h2A) || (in_data == 8'h2F);
    in_hash   = (in_data == 8'h23);
    in_space  = (in_data == 8'h20);
    // clear outranks a transfer in the same cycle; the character is dropped.
    xfer      = (state == LOAD) && in_valid && !clear && !rst;
    full      = (wr_cnt_q == LAST_FREE);
    do_write  = xfer && (in_digit || in_op || in_hash);
    bad_char  = xfer && !(in_digit || in_op || in_hash || in_space);
    // In the last free slot a legal character is replaced by the terminator.
    wr_char   = (in_hash || full) ? 8'h23 : in_data;
    go_loaded = do_write && (in_hash || full);
    at_end    = ({1'b0, rd_ptr} == (wr_cnt_q - 1'b1));
  end

  // Next-state logic for the LOAD/LOADED controller.
  always_comb begin
    state_nxt = state;
    if (clear)          state_nxt = LOAD;
    else if (go_loaded) state_nxt = LOADED;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Pointers, write count and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr   <= wr_ptr + 1'b1;
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
      if (bad_char) err_q <= 1'b1;
      if (do_write && full && !in_hash) ovf_q <= 1'b1;
      if (state == LOADED) begin
        if (rewind)                   rd_ptr <= '0;
        else if (index_cnt && !at_end) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Character storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_char;
  end

  // Combinational decode of the character at the read pointer.
  always_comb begin
    cur_char    = '0;
    digit       = '0;
    is_operand  = 1'b0;
    is_operator = 1'b0;
    is_hash     = 1'b0;
    if (state == LOADED) begin
      cur_char    = mem[rd_ptr];
      is_operand  = (cur_char >= 8'h30) && (cur_char <= 8'h39);
      is_operator = (cur_char == 8'h2B) || (cur_char == 8'h2D) ||
                    (cur_char == 8'h2A) || (cur_char == 8'h2F);
      is_hash     = (cur_char == 8'h23);
      if (is_operand) digit = cur_char[3:0];
    end
  end

  assign in_ready = (state == LOAD);
  assign loaded   = (state == LOADED);
  assign err      = err_q;
  assign overflow = ovf_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_expr_buffer.sv
// Scoreboard bench for expr_buffer: a 32-deep instance and a 4-deep instance.
module tb_expr_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A (DEPTH 32)
  logic       a_valid = 1'b0, a_clear = 1'b0, a_rewind = 1'b0, a_idx = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_loaded, a_opnd, a_oper, a_hash, a_err, a_ovf;
  logic [7:0] a_char;
  logic [3:0] a_digit;
  logic [5:0] a_wc;

  // Instance B (DEPTH 4)
  logic       b_valid = 1'b0, b_clear = 1'b0, b_rewind = 1'b0, b_idx = 1'b0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_loaded, b_opnd, b_oper, b_hash, b_err, b_ovf;
  logic [7:0] b_char;
  logic [3:0] b_digit;
  logic [2:0] b_wc;

  expr_buffer #(.DEPTH(32), .AW(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .clear(a_clear), .rewind(a_rewind),
    .index_cnt(a_idx), .loaded(a_loaded), .cur_char(a_char),
    .digit(a_digit), .is_operand(a_opnd), .is_operator(a_oper),
    .is_hash(a_hash), .err(a_err), .overflow(a_ovf), .wr_count(a_wc));

  expr_buffer #(.DEPTH(4), .AW(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .clear(b_clear), .rewind(b_rewind),
    .index_cnt(b_idx), .loaded(b_loaded), .cur_char(b_char),
    .digit(b_digit), .is_operand(b_opnd), .is_operator(b_oper),
    .is_hash(b_hash), .err(b_err), .overflow(b_ovf), .wr_count(b_wc));

  // Packed observation: {loaded,in_ready,err,overflow,operand,operator,hash,digit,cur_char,wr_count}
  typedef struct {
    string       name;
    bit          sel;
    logic [24:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [2:0] F_NONE = 3'b000, F_OPND = 3'b100,
                         F_OPER = 3'b010, F_HASH = 3'b001;

  function automatic logic [24:0] obs_a();
    return {a_loaded, a_ready, a_err, a_ovf, a_opnd, a_oper, a_hash,
            a_digit, a_char, a_wc};
  endfunction

  function automatic logic [24:0] obs_b();
    return {b_loaded, b_ready, b_err, b_ovf, b_opnd, b_oper, b_hash,
            b_digit, b_char, {3'b000, b_wc}};
  endfunction

  task automatic expect_state(input string name, input bit sel,
                              input bit ld, input bit rdy, input bit e,
                              input bit o, input logic [2:0] fl,
                              input logic [3:0] dg, input logic [7:0] ch,
                              input logic [5:0] wc);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = {ld, rdy, e, o, fl, dg, ch, wc};
    q.push_back(c);
  endtask

  // Monitor: pop and compare against the DUT at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [24:0] act;
      c   = q.pop_front();
      act = c.sel ? obs_b() : obs_a();
      n_total++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [7:0] ch);
    if (sel) begin b_valid = 1'b1; b_data = ch; end
    else     begin a_valid = 1'b1; a_data = ch; end
    cyc();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send(sel, s[i]);
  endtask

  task automatic idx(input bit sel);
    if (sel) b_idx = 1'b1; else a_idx = 1'b1;
    cyc();
    a_idx = 1'b0;
    b_idx = 1'b0;
  endtask

  task automatic do_clear(input bit sel);
    if (sel) b_clear = 1'b1; else a_clear = 1'b1;
    cyc();
    a_clear = 1'b0;
    b_clear = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    expect_state("reset_a", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);
    expect_state("reset_b", 1, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);
    cyc();

    // "12+3#" then walk the pointer, including saturation at '#'
    send_str(0, "12+3#");
    expect_state("load_12p3", 0, 1, 0, 0, 0, F_OPND, 4'd1, 8'h31, 6'd5);
    idx(0); expect_state("step1_2",    0, 1, 0, 0, 0, F_OPND, 4'd2, 8'h32, 6'd5);
    idx(0); expect_state("step2_plus", 0, 1, 0, 0, 0, F_OPER, 4'd0, 8'h2B, 6'd5);
    idx(0); expect_state("step3_3",    0, 1, 0, 0, 0, F_OPND, 4'd3, 8'h33, 6'd5);
    idx(0); expect_state("step4_hash", 0, 1, 0, 0, 0, F_HASH, 4'd0, 8'h23, 6'd5);
    for (int i = 0; i < 3; i++) begin
      idx(0);
      expect_state("saturate", 0, 1, 0, 0, 0, F_HASH, 4'd0, 8'h23, 6'd5);
    end

    // "7 * 8#" with spaces, then rewind mid-read
    do_clear(0);
    expect_state("clear_a", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);
    send_str(0, "7 * 8#");
    expect_state("load_spaces", 0, 1, 0, 0, 0, F_OPND, 4'd7, 8'h37, 6'd4);
    idx(0); idx(0);
    expect_state("read_8", 0, 1, 0, 0, 0, F_OPND, 4'd8, 8'h38, 6'd4);
    a_rewind = 1'b1; cyc(); a_rewind = 1'b0;
    expect_state("rewind", 0, 1, 0, 0, 0, F_OPND, 4'd7, 8'h37, 6'd4);
    idx(0);
    expect_state("read_star", 0, 1, 0, 0, 0, F_OPER, 4'd0, 8'h2A, 6'd4);
    a_rewind = 1'b1; a_idx = 1'b1; cyc(); a_rewind = 1'b0; a_idx = 1'b0;
    expect_state("rewind_vs_idx", 0, 1, 0, 0, 0, F_OPND, 4'd7, 8'h37, 6'd4);

    // "5a+1#": illegal character sets err and is not stored
    do_clear(0);
    send_str(0, "5a");
    expect_state("err_set", 0, 0, 1, 1, 0, F_NONE, 4'd0, 8'h00, 6'd1);
    send_str(0, "+1#");
    expect_state("err_load", 0, 1, 0, 1, 0, F_OPND, 4'd5, 8'h35, 6'd4);
    idx(0); expect_state("err_plus", 0, 1, 0, 1, 0, F_OPER, 4'd0, 8'h2B, 6'd4);
    idx(0); expect_state("err_1",    0, 1, 0, 1, 0, F_OPND, 4'd1, 8'h31, 6'd4);
    idx(0); expect_state("err_hash", 0, 1, 0, 1, 0, F_HASH, 4'd0, 8'h23, 6'd4);
    do_clear(0);
    expect_state("err_clear", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);

    // rst and clear mid-load, then a fresh "8#"
    send_str(0, "99");
    expect_state("partial", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    expect_state("rst_mid", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);
    send_str(0, "99");
    do_clear(0);
    expect_state("clear_mid", 0, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);
    send_str(0, "8#");
    expect_state("load_8", 0, 1, 0, 0, 0, F_OPND, 4'd8, 8'h38, 6'd2);

    // DEPTH 4: "1234#" truncates to "123#"
    send_str(1, "123");
    expect_state("b_three", 1, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd3);
    send(1, 8'h34);
    expect_state("b_ovf", 1, 1, 0, 0, 1, F_OPND, 4'd1, 8'h31, 6'd4);
    send(1, 8'h23);
    expect_state("b_hash_ign", 1, 1, 0, 0, 1, F_OPND, 4'd1, 8'h31, 6'd4);
    idx(1); expect_state("b_2",    1, 1, 0, 0, 1, F_OPND, 4'd2, 8'h32, 6'd4);
    idx(1); expect_state("b_3",    1, 1, 0, 0, 1, F_OPND, 4'd3, 8'h33, 6'd4);
    idx(1); expect_state("b_hash", 1, 1, 0, 0, 1, F_HASH, 4'd0, 8'h23, 6'd4);
    idx(1); expect_state("b_hold", 1, 1, 0, 0, 1, F_HASH, 4'd0, 8'h23, 6'd4);
    do_clear(1);
    expect_state("b_clear", 1, 0, 1, 0, 0, F_NONE, 4'd0, 8'h00, 6'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
